branch_buffered: RTL and testbench
==================================

# branch_buffered

Dataflow branch with registered outputs. It joins one `data` token with one `condition` token and routes the data to `trueOut` (condition=1) or `falseOut` (condition=0); the other output gets nothing. Each output has its own 2-entry elastic buffer, so input readiness never depends combinationally on `trueOut_ready`/`falseOut_ready`. It is the splitting counterpart of the select/merge side of the handshake library and sits wherever a control-dependent value fans out to two basic blocks.

## Interface
- DATA_WIDTH, 32, width of the data token and both outputs
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low
- condition  in  1  routing select; 1 = true side
- condition_valid  in  1  condition token present
- condition_ready  out  1  condition token consumed this cycle (or none offered)
- data  in  DATA_WIDTH  payload
- data_valid  in  1  payload token present
- data_ready  out  1  payload token consumed this cycle (or none offered)
- trueOut  out  DATA_WIDTH  head entry of true-side buffer
- trueOut_valid  out  1  true-side buffer non-empty
- trueOut_ready  in  1  consumer accepts trueOut
- falseOut  out  DATA_WIDTH  head entry of false-side buffer
- falseOut_valid  out  1  false-side buffer non-empty
- falseOut_ready  in  1  consumer accepts falseOut

## Operation
- Per side S in {true, false}: 2-slot storage, 1-bit head pointer, 1-bit tail pointer, and a count in {EMPTY=0, ONE=1, TWO=2}.
- space_S = (count_S != TWO), computed from registered state only.
- fire = condition_valid & data_valid & (condition ? space_true : space_false).
- condition_ready = !condition_valid | fire; data_ready = !data_valid | fire. Both tokens are consumed together or not at all.
- push_S = fire & (condition selects S): write data to slot[tail_S], then tail_S toggles.
- pop_S = S_valid & S_ready: head_S toggles.
- Count transitions: push only: +1. Pop only: −1. Both, or neither: unchanged. Push is never asserted when count is TWO (no bypass: a same-cycle pop at TWO does not free space for that cycle).
- S_valid = (count_S != EMPTY). The S output is slot[head_S].
- A side not selected by the condition ignores the token entirely. No antitoken generation or killing happens in this block.
- Once asserted, a valid output stays asserted, with stable data, until it is popped.

## Timing
- Reset (rst=0, asynchronous): both counts EMPTY, all pointers 0, slots 0. Outputs: trueOut_valid=0, falseOut_valid=0, trueOut=0, falseOut=0. condition_ready and data_ready follow their combinational equations, so with counts EMPTY each equals 1 while its valid is low, and 1 when fire. Deassertion is taken at the next clk edge.
- Reset mid-operation discards all buffered tokens immediately. Tokens presented during reset are not stored.
- Latency: a token that fires in cycle N is visible on its output with valid=1 from cycle N+1.
- Throughput: 1 token/cycle per side when the consumer is always ready (count alternates EMPTY→ONE, then holds ONE).
- Full side: at count TWO, the input stalls (fire=0) only if the condition selects that side. Tokens destined for the other side continue at full rate.
- Pointer wrap: 1-bit pointers wrap from 1 to 0 naturally. FIFO order is preserved per side.
- Combinational paths: condition/condition_valid/data_valid → *_ready. There is no path from trueOut_ready/falseOut_ready to any input ready.

## Test plan
- Reset then idle: assert rst=0 mid-stream with 2 tokens buffered on the true side -> trueOut_valid=0 and falseOut_valid=0 immediately. After release, the next token appears alone.
- Routing: send (cond=1, 0xA5), then (cond=0, 0x3C), with both consumers ready -> trueOut=0xA5 valid in cycle 1 only; falseOut=0x3C valid in cycle 2 only.
- Join: data_valid=1 for 3 cycles with condition_valid=0 -> no fire, data_ready=0. Raise condition_valid -> fire in that cycle, and condition_ready=data_ready=1.
- Backpressure: trueOut_ready=0, send 3 true tokens 1,2,3 -> first two accepted, third stalls (data_ready=0). Release ready -> outputs 1,2,3 in order. No push occurs in the cycle where the count is TWO and a pop happens.
- Side independence: true side full (TWO) with ready=0, then send 4 false tokens back to back -> all accepted at 1/cycle; true side unchanged.
- Streaming: 100 random tokens, random condition, random ready -> scoreboard shows per-side order preserved, no loss or duplication, and valid/data stable while stalled.

Source files
------------

// File: rtl/branch_buffered.sv
// branch_buffered: joins a data token with a condition token and routes the data to trueOut or falseOut.
// Each output side has its own 2-entry buffer, so no input ready depends on a downstream ready.
// Ports: clk, rst (async active-low) | condition/condition_valid/condition_ready |
//        data/data_valid/data_ready | trueOut/_valid/_ready | falseOut/_valid/_ready
module branch_buffered #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  condition,
  input  logic                  condition_valid,
  output logic                  condition_ready,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic [DATA_WIDTH-1:0] trueOut,
  output logic                  trueOut_valid,
  input  logic                  trueOut_ready,
  output logic [DATA_WIDTH-1:0] falseOut,
  output logic                  falseOut_valid,
  input  logic                  falseOut_ready
);
  logic [1:0]            w_space, w_valid, w_ready, w_push;
  logic [DATA_WIDTH-1:0] w_out [2];
  logic                  w_fire;
  assign w_ready = {trueOut_ready, falseOut_ready};
  // space comes from registered counts only: a pop at TWO never frees room in the same cycle
  assign w_fire = condition_valid & data_valid & (condition ? w_space[1] : w_space[0]);
  assign condition_ready = !condition_valid | w_fire;
  assign data_ready = !data_valid | w_fire;
  for (genvar s = 0; s < 2; s++) begin : g_side
    logic [DATA_WIDTH-1:0] r_slot [2];
    logic                  r_head, r_tail, w_pop;
    logic [1:0]            r_cnt;
    assign w_space[s] = r_cnt != 2'd2;
    assign w_valid[s] = r_cnt != 2'd0;
    assign w_push[s] = w_fire & (condition == 1'(s));
    assign w_pop = w_valid[s] & w_ready[s];
    assign w_out[s] = r_slot[r_head];
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        r_slot[0] <= '0;
        r_slot[1] <= '0;
        r_head <= 1'b0;
        r_tail <= 1'b0;
        r_cnt <= 2'd0;
      end else begin
        if (w_push[s]) begin
          r_slot[r_tail] <= data;
          r_tail <= !r_tail;
        end
        if (w_pop) r_head <= !r_head;
        r_cnt <= (w_push[s] && !w_pop) ? r_cnt + 2'd1 :
                 (!w_push[s] && w_pop) ? r_cnt - 2'd1 : r_cnt;
      end
  end
  assign trueOut = w_out[1];
  assign falseOut = w_out[0];
  assign trueOut_valid = w_valid[1];
  assign falseOut_valid = w_valid[0];
endmodule

// File: tb/tb_branch_buffered.sv
// tb_branch_buffered: directed and random checks of branch_buffered against per-side FIFO queues.
module tb_branch_buffered;
  localparam int DW = 32;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          condition = 1'b0, condition_valid = 1'b0, condition_ready;
  logic [DW-1:0] data = '0;
  logic          data_valid = 1'b0, data_ready;
  logic [DW-1:0] trueOut, falseOut;
  logic          trueOut_valid, falseOut_valid;
  logic          trueOut_ready = 1'b0, falseOut_ready = 1'b0;
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] qt[$];
  logic [DW-1:0] qf[$];

  branch_buffered #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .condition(condition), .condition_valid(condition_valid), .condition_ready(condition_ready),
    .data(data), .data_valid(data_valid), .data_ready(data_ready),
    .trueOut(trueOut), .trueOut_valid(trueOut_valid), .trueOut_ready(trueOut_ready),
    .falseOut(falseOut), .falseOut_valid(falseOut_valid), .falseOut_ready(falseOut_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: drive, check against the queue model, then advance the model at the edge.
  task automatic cyc(input logic cv, input logic c, input logic dv, input logic [DW-1:0] d,
                     input logic tr, input logic fr);
    logic fire, pt, pf;
    condition_valid = cv;
    condition = c;
    data_valid = dv;
    data = d;
    trueOut_ready = tr;
    falseOut_ready = fr;
    #1;
    fire = cv && dv && (c ? qt.size() < 2 : qf.size() < 2);
    pt = qt.size() != 0 && tr;
    pf = qf.size() != 0 && fr;
    chk("data_ready", DW'(data_ready), DW'(!dv || fire));
    chk("condition_ready", DW'(condition_ready), DW'(!cv || fire));
    chk("trueOut_valid", DW'(trueOut_valid), DW'(qt.size() != 0));
    chk("falseOut_valid", DW'(falseOut_valid), DW'(qf.size() != 0));
    if (qt.size() != 0) chk("trueOut", trueOut, qt[0]);
    if (qf.size() != 0) chk("falseOut", falseOut, qf[0]);
    @(posedge clk);
    if (rst) begin
      if (pt) void'(qt.pop_front());
      if (pf) void'(qf.pop_front());
      if (fire && c) qt.push_back(d);
      if (fire && !c) qf.push_back(d);
    end
    #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_trueOut_valid", DW'(trueOut_valid), '0);
    chk("rst_falseOut_valid", DW'(falseOut_valid), '0);
    chk("rst_trueOut", trueOut, '0);
    chk("rst_falseOut", falseOut, '0);
  endtask

  initial begin
    #3;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    cyc(1, 1, 1, 32'hDEAD_0001, 1, 1);
    rst = 1'b1;
    cyc(0, 0, 0, 0, 1, 1);
    chk("no_token_from_reset", DW'(trueOut_valid), '0);
    // routing
    cyc(1, 1, 1, 32'hA5, 1, 1);
    cyc(1, 0, 1, 32'h3C, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    // join: data waits for condition
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 32'h77, 1, 1);
    cyc(1, 1, 1, 32'h77, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    // backpressure on true side
    cyc(1, 1, 1, 1, 0, 1);
    cyc(1, 1, 1, 2, 0, 1);
    cyc(1, 1, 1, 3, 0, 1);
    cyc(1, 1, 1, 3, 1, 1);
    cyc(1, 1, 1, 3, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    // side independence: true full, false streams
    cyc(1, 1, 1, 32'h10, 0, 1);
    cyc(1, 1, 1, 32'h11, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1, 32'h20 + i, 0, 1);
    chk("true_depth_held", DW'(qt.size()), 2);
    // async reset mid-stream with two true tokens buffered
    condition_valid = 1'b1;
    condition = 1'b1;
    data_valid = 1'b1;
    data = 32'h99;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs();
    qt.delete();
    qf.delete();
    @(posedge clk);
    #1;
    cyc(1, 1, 1, 32'h98, 0, 0);
    rst = 1'b1;
    cyc(1, 0, 1, 32'h55, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 1, 1);
    // random streaming
    for (int i = 0; i < 300; i++)
      cyc(1'($urandom), 1'($urandom), 1'($urandom), $urandom, 1'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1);
    chk("drained_true", DW'(qt.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
